// File: rtl/logic_op_pipe.sv
// Registered bitwise operator with valid/ready handshake and an XOR-fold
// packet accumulate mode producing one checksum word per packet.
module logic_op_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataOut,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_count,
  output logic             acc_busy
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_XNOR = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_ACC  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               outValid_q, outValid_d;
  logic [WIDTH-1:0]   outData_q, outData_d;
  logic               outZero_q, outZero_d;
  logic [CNT_W-1:0]   outCount_q, outCount_d;

  logic               accept;
  logic               consume;
  logic [WIDTH-1:0]   opResult;
  logic [WIDTH-1:0]   foldResult;
  logic [CNT_W-1:0]   cntInc;
  logic               load;
  logic [WIDTH-1:0]   loadData;
  logic [CNT_W-1:0]   loadCount;

  assign in_ready = rst_n & (~outValid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign consume  = outValid_q & out_ready;

  always_comb begin
    opResult = data1;
    case (op)
      OP_AND:  opResult = data1 & data2;
      OP_OR:   opResult = data1 | data2;
      OP_XOR:  opResult = data1 ^ data2;
      OP_XNOR: opResult = ~(data1 ^ data2);
      OP_NAND: opResult = ~(data1 & data2);
      OP_NOR:  opResult = ~(data1 | data2);
      default: opResult = data1;
    endcase
  end

  // An IDLE packet starts from an empty fold and a count of one; the counter
  // sticks at all-ones while the fold keeps absorbing words.
  always_comb begin
    foldResult = ((state_q == ACC) ? acc_q : '0) ^ data1 ^ data2;
    cntInc     = CNT_W'(1);
    if (state_q == ACC) begin
      cntInc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    loadData   = opResult;
    loadCount  = CNT_W'(1);
    if (accept) begin
      if (op == OP_ACC) begin
        if (in_last) begin
          load      = 1'b1;
          loadData  = foldResult;
          loadCount = cntInc;
          state_d   = IDLE;
          acc_d     = '0;
          cnt_d     = '0;
        end else begin
          acc_d   = foldResult;
          cnt_d   = cntInc;
          state_d = ACC;
        end
      end else begin
        load = 1'b1;
      end
    end
  end

  always_comb begin
    outValid_d = outValid_q & ~consume;
    outData_d  = outData_q;
    outZero_d  = outZero_q;
    outCount_d = outCount_q;
    if (load) begin
      outValid_d = 1'b1;
      outData_d  = loadData;
      outZero_d  = (loadData == '0);
      outCount_d = loadCount;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outZero_q  <= 1'b0;
      outCount_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outZero_q  <= outZero_d;
      outCount_q <= outCount_d;
    end
  end

  assign out_valid = outValid_q;
  assign dataOut   = outData_q;
  assign out_zero  = outZero_q;
  assign out_count = outCount_q;
  assign acc_busy  = (state_q == ACC);

endmodule

// File: tb/tb_logic_op_pipe.sv
// Bench for logic_op_pipe: directed vectors plus randomized traffic checked
// against a queue-based model, and a narrow-counter instance for saturation.
module tb_logic_op_pipe;

  localparam logic [2:0] AND_OP  = 3'b000;
  localparam logic [2:0] XOR_OP  = 3'b010;
  localparam logic [2:0] ACC_OP  = 3'b110;
  localparam logic [2:0] PASS_OP = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_zero, acc_busy;
  logic [2:0]  op;
  logic [7:0]  data1, data2, dataOut, out_count;

  logic        inValid16, inReady16, inLast16, outValid16, outZero16, accBusy16;
  logic [2:0]  op16;
  logic [15:0] data1_16, data2_16, dataOut16;
  logic [1:0]  outCount16;

  int nTests = 0;
  int nFail  = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       zero;
    logic [7:0] cnt;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] pkt[$];

  typedef struct {
    logic [2:0] op;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] expOut;
  } vec_t;

  vec_t vecs[8];

  logic_op_pipe #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .data1(data1), .data2(data2), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .dataOut(dataOut), .out_zero(out_zero),
    .out_count(out_count), .acc_busy(acc_busy)
  );

  logic_op_pipe #(.WIDTH(16), .CNT_W(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid16), .in_ready(inReady16), .op(op16),
    .data1(data1_16), .data2(data2_16), .in_last(inLast16), .out_valid(outValid16),
    .out_ready(1'b1), .dataOut(dataOut16), .out_zero(outZero16),
    .out_count(outCount16), .acc_busy(accBusy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] refOp(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return ~(a ^ b);
      3'b100:  return ~(a & b);
      3'b101:  return ~(a | b);
      default: return a;
    endcase
  endfunction

  // Model of one accepted word: plain ops emit immediately, ACC words collect
  // into a packet list that is XOR-folded when the last word arrives.
  task automatic modelAccept(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic l);
    exp_t e;
    logic [7:0] x;
    if (o != ACC_OP) begin
      e.data = refOp(o, a, b);
      e.zero = (e.data == 8'h00);
      e.cnt  = 8'd1;
      expQ.push_back(e);
    end else begin
      pkt.push_back(a ^ b);
      if (l) begin
        x = 8'h00;
        foreach (pkt[i]) x ^= pkt[i];
        e.data = x;
        e.zero = (x == 8'h00);
        e.cnt  = (pkt.size() > 255) ? 8'd255 : 8'(pkt.size());
        expQ.push_back(e);
        pkt.delete();
      end
    end
  endtask

  task automatic checkOutput();
    logic expReady;
    expReady = rst_n & ((expQ.size() == 0) | out_ready);
    checkEq("in_ready", 32'(in_ready), 32'(expReady));
    checkEq("out_valid", 32'(out_valid), 32'(expQ.size() != 0));
    checkEq("acc_busy", 32'(acc_busy), 32'(pkt.size() != 0));
    if (expQ.size() != 0) begin
      checkEq("dataOut", 32'(dataOut), 32'(expQ[0].data));
      checkEq("out_zero", 32'(out_zero), 32'(expQ[0].zero));
      checkEq("out_count", 32'(out_count), 32'(expQ[0].cnt));
    end
  endtask

  // Drive one cycle from a negedge, check against the model, then advance.
  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [7:0] a,
                               input logic [7:0] b, input logic l, input logic r);
    logic acc;
    in_valid  = v;
    op        = o;
    data1     = a;
    data2     = b;
    in_last   = l;
    out_ready = r;
    #1;
    checkOutput();
    acc = v & ((expQ.size() == 0) | r);
    if ((expQ.size() != 0) && r) void'(expQ.pop_front());
    if (acc) modelAccept(o, a, b, l);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checkEq("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    expQ.delete();
    pkt.delete();
    checkEq("rst_out_valid", 32'(out_valid), 32'd0);
    checkEq("rst_dataOut", 32'(dataOut), 32'd0);
    checkEq("rst_out_zero", 32'(out_zero), 32'd0);
    checkEq("rst_out_count", 32'(out_count), 32'd0);
    checkEq("rst_acc_busy", 32'(acc_busy), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic step16(input logic v, input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic l);
    inValid16 = v;
    op16      = o;
    data1_16  = a;
    data2_16  = b;
    inLast16  = l;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 3'b000; data1 = 8'h00; data2 = 8'h00;
    in_last = 1'b0; out_ready = 1'b1;
    inValid16 = 1'b0; op16 = 3'b000; data1_16 = 16'h0; data2_16 = 16'h0; inLast16 = 1'b0;

    vecs[0] = '{3'b000, 8'hF0, 8'h3C, 8'h30};
    vecs[1] = '{3'b001, 8'hF0, 8'h3C, 8'hFC};
    vecs[2] = '{3'b010, 8'hF0, 8'h3C, 8'hCC};
    vecs[3] = '{3'b011, 8'hF0, 8'h3C, 8'h33};
    vecs[4] = '{3'b100, 8'hF0, 8'h3C, 8'hCF};
    vecs[5] = '{3'b101, 8'hF0, 8'h3C, 8'h03};
    vecs[6] = '{3'b111, 8'hF0, 8'h3C, 8'hF0};
    vecs[7] = '{3'b010, 8'h55, 8'h50, 8'h05};

    @(negedge clk);
    doReset();

    applyStimulus(1'b1, XOR_OP, 8'h55, 8'h50, 1'b0, 1'b1);
    checkEq("t1_valid", 32'(out_valid), 32'd1);
    checkEq("t1_data", 32'(dataOut), 32'h05);
    checkEq("t1_zero", 32'(out_zero), 32'd0);
    checkEq("t1_count", 32'(out_count), 32'd1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].d1, vecs[i].d2, 1'b0, 1'b1);
      checkEq($sformatf("sweep%0d_valid", i), 32'(out_valid), 32'd1);
      checkEq($sformatf("sweep%0d_data", i), 32'(dataOut), 32'(vecs[i].expOut));
    end
    applyStimulus(1'b0, AND_OP, 8'h00, 8'h00, 1'b0, 1'b1);

    applyStimulus(1'b1, ACC_OP, 8'h01, 8'h02, 1'b0, 1'b1);
    checkEq("t3_busy_first", 32'(acc_busy), 32'd1);
    checkEq("t3_no_out", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, ACC_OP, 8'h04, 8'h08, 1'b0, 1'b1);
    applyStimulus(1'b1, ACC_OP, 8'h10, 8'h20, 1'b1, 1'b1);
    checkEq("t3_valid", 32'(out_valid), 32'd1);
    checkEq("t3_data", 32'(dataOut), 32'h3F);
    checkEq("t3_count", 32'(out_count), 32'd3);
    checkEq("t3_busy_last", 32'(acc_busy), 32'd0);
    applyStimulus(1'b0, AND_OP, 8'h00, 8'h00, 1'b0, 1'b1);

    applyStimulus(1'b1, XOR_OP, 8'h12, 8'h34, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, PASS_OP, 8'h77, 8'h00, 1'b0, 1'b0);
      checkEq($sformatf("t4_hold%0d", i), 32'(dataOut), 32'h26);
    end
    applyStimulus(1'b1, PASS_OP, 8'h77, 8'h00, 1'b0, 1'b1);
    checkEq("t4_next", 32'(dataOut), 32'h77);
    applyStimulus(1'b0, AND_OP, 8'h00, 8'h00, 1'b0, 1'b1);

    applyStimulus(1'b1, ACC_OP, 8'h11, 8'h22, 1'b0, 1'b1);
    applyStimulus(1'b1, ACC_OP, 8'h44, 8'h08, 1'b0, 1'b1);
    doReset();
    applyStimulus(1'b1, ACC_OP, 8'hAA, 8'hAA, 1'b1, 1'b1);
    checkEq("t5_valid", 32'(out_valid), 32'd1);
    checkEq("t5_data", 32'(dataOut), 32'h00);
    checkEq("t5_zero", 32'(out_zero), 32'd1);
    checkEq("t5_count", 32'(out_count), 32'd1);
    applyStimulus(1'b0, AND_OP, 8'h00, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(3) != 0,
                      ($urandom_range(2) == 0) ? ACC_OP : 3'($urandom),
                      8'($urandom), 8'($urandom),
                      $urandom_range(3) == 0,
                      $urandom_range(3) != 0);
      end
    end
    applyStimulus(1'b0, AND_OP, 8'h00, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, AND_OP, 8'h00, 8'h00, 1'b0, 1'b1);

    step16(1'b1, ACC_OP, 16'h1234, 16'h0000, 1'b0);
    checkEq("w16_busy", 32'(accBusy16), 32'd1);
    checkEq("w16_no_out", 32'(outValid16), 32'd0);
    step16(1'b1, ACC_OP, 16'h0001, 16'h0000, 1'b0);
    step16(1'b1, AND_OP, 16'hFF00, 16'h0F0F, 1'b0);
    checkEq("w16_and_valid", 32'(outValid16), 32'd1);
    checkEq("w16_and_data", 32'(dataOut16), 32'h0F00);
    checkEq("w16_and_count", 32'(outCount16), 32'd1);
    checkEq("w16_and_busy", 32'(accBusy16), 32'd1);
    step16(1'b1, ACC_OP, 16'h1234, 16'h0000, 1'b0);
    checkEq("w16_mid_valid", 32'(outValid16), 32'd0);
    step16(1'b1, ACC_OP, 16'h0001, 16'h0000, 1'b0);
    step16(1'b1, ACC_OP, 16'h1234, 16'h0000, 1'b1);
    checkEq("w16_valid", 32'(outValid16), 32'd1);
    checkEq("w16_data", 32'(dataOut16), 32'h1234);
    checkEq("w16_count_sat", 32'(outCount16), 32'd3);
    checkEq("w16_zero", 32'(outZero16), 32'd0);
    checkEq("w16_busy_end", 32'(accBusy16), 32'd0);
    step16(1'b0, AND_OP, 16'h0000, 16'h0000, 1'b0);
    checkEq("w16_drained", 32'(outValid16), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
